// File: rtl/alu_group_sequencer.sv
// Registered, phase-driven ALU-group sequencer: latches decoded control at DECODE, holds it to COMMIT,
// and iterates multi-cycle ALU ops while stalling the phase generator.
module alu_group_sequencer #(
    parameter int                     OPW        = 4,
    parameter int                     ITERW      = 4,
    parameter logic [(1<<OPW)-1:0]    MULTI_MASK = '0,
    parameter int                     ITER_DEF   = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [13:0]    INSTRUCTION,
    input  logic           GROUP_VALID,
    input  logic           DECODE,
    input  logic           EXECUTE,
    input  logic           COMMIT,
    output logic [3:0]     REG_SEQX,
    output logic [1:0]     REGA_ADDRX,
    output logic [2:0]     REGB_ADDRX,
    output logic [OPW-1:0] ALU_OPX,
    output logic           CCL_LD,
    output logic [2:0]     ALUA_SRCX,
    output logic [2:0]     ALUB_SRCX,
    output logic           ALU_STEP,
    output logic           STALL,
    output logic           DONE
);

    // Operation / mode encodings
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_BIT = 4'h7;

    localparam logic [1:0] MODE_ALU_REG_REG = 2'd0;
    localparam logic [1:0] MODE_ALU_REG_U4  = 2'd1;
    localparam logic [1:0] MODE_ALU_REGA_U8 = 2'd2;
    localparam logic [1:0] MODE_ALU_REGA_S8 = 2'd3;

    localparam logic [3:0] REG_SEQX_NONE    = 4'd0;
    localparam logic [3:0] REG_SEQX_RDA_IMM = 4'd1;
    localparam logic [3:0] REG_SEQX_RDA_RDB = 4'd2;
    localparam logic [3:0] REG_SEQX_LDA_IMM = 4'd3;
    localparam logic [3:0] REG_SEQX_LDA_RDB = 4'd4;
    localparam logic [3:0] REG_SEQX_UPA_IMM = 4'd5;
    localparam logic [3:0] REG_SEQX_UPA_RDB = 4'd6;

    localparam logic [1:0] REGA_ADDRX_ARGA = 2'd0;
    localparam logic [1:0] REGA_ADDRX_RA   = 2'd1;
    localparam logic [2:0] REGB_ADDRX_ARGB = 3'd0;
    localparam logic [2:0] REGB_ADDRX_RB   = 3'd1;

    localparam logic [2:0] ALUA_SRCX_REG_A = 3'd0;
    localparam logic [2:0] ALUB_SRCX_REG_B = 3'd0;
    localparam logic [2:0] ALUB_SRCX_U4    = 3'd1;
    localparam logic [2:0] ALUB_SRCX_U8    = 3'd2;
    localparam logic [2:0] ALUB_SRCX_S8    = 3'd3;

    localparam int MAX_N = (1 << ITERW) - 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ITER, S_WAIT_C} state_t;

    state_t           state_q, state_d;
    logic [ITERW-1:0] cnt_q, cnt_d, n_load;
    logic             ccl_q;
    logic             accept, release_ctl, step, stall, final_step, done_d;

    logic [OPW-1:0]   op;
    logic [1:0]       mode;
    logic             is_imm, multi;
    logic [3:0]       dec_seq;
    logic [1:0]       dec_rega;
    logic [2:0]       dec_regb, dec_alub;
    int               n_int;
    logic             unused_ok;

    assign op        = INSTRUCTION[13 -: OPW];
    assign mode      = INSTRUCTION[9:8];
    assign is_imm    = (mode != MODE_ALU_REG_REG);
    assign multi     = MULTI_MASK[op];
    assign unused_ok = ^INSTRUCTION[7:4];

    // Decode of the instruction presented at DECODE; captured into the control registers on accept
    always_comb begin
        dec_seq  = is_imm ? REG_SEQX_UPA_IMM : REG_SEQX_UPA_RDB;
        dec_rega = REGA_ADDRX_ARGA;
        dec_regb = REGB_ADDRX_ARGB;
        dec_alub = ALUB_SRCX_REG_B;
        if (op == OPW'(OP_CMP) || op == OPW'(OP_BIT))
            dec_seq = is_imm ? REG_SEQX_RDA_IMM : REG_SEQX_RDA_RDB;
        else if (op == OPW'(OP_MOV))
            dec_seq = is_imm ? REG_SEQX_LDA_IMM : REG_SEQX_LDA_RDB;
        case (mode)
            MODE_ALU_REG_U4:  dec_alub = ALUB_SRCX_U4;
            MODE_ALU_REGA_U8: begin
                dec_rega = REGA_ADDRX_RA;
                dec_alub = ALUB_SRCX_U8;
            end
            MODE_ALU_REGA_S8: begin
                dec_rega = REGA_ADDRX_RA;
                dec_regb = REGB_ADDRX_RB;
                dec_alub = ALUB_SRCX_S8;
            end
            default: dec_alub = ALUB_SRCX_REG_B;
        endcase
    end

    // Iteration count, clamped to [1, MAX_N]
    always_comb begin
        n_int = 1;
        if (multi) begin
            if (mode == MODE_ALU_REG_U4)
                n_int = (INSTRUCTION[3:0] == 4'd0) ? 1 : int'(INSTRUCTION[3:0]);
            else
                n_int = ITER_DEF;
        end
        if (n_int < 1)     n_int = 1;
        if (n_int > MAX_N) n_int = MAX_N;
        n_load = n_int[ITERW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        release_ctl = 1'b0;
        step        = 1'b0;
        stall       = 1'b0;
        final_step  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (DECODE && GROUP_VALID) begin
                    accept  = 1'b1;
                    cnt_d   = n_load;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (EXECUTE) begin
                    step = 1'b1;
                    if (cnt_q <= ITERW'(1)) begin
                        final_step = 1'b1;
                        state_d    = S_WAIT_C;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = cnt_q - ITERW'(1);
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                // Iterations run on their own; EXECUTE is frozen by STALL
                step  = 1'b1;
                cnt_d = cnt_q - ITERW'(1);
                if (cnt_q <= ITERW'(1)) begin
                    final_step = 1'b1;
                    state_d    = S_WAIT_C;
                end else begin
                    stall = 1'b1;
                end
            end
            S_WAIT_C: begin
                if (COMMIT) begin
                    done_d = 1'b1;
                    if (DECODE && GROUP_VALID) begin
                        accept  = 1'b1;
                        cnt_d   = n_load;
                        state_d = S_ARMED;
                    end else begin
                        release_ctl = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ccl_q      <= 1'b0;
            DONE       <= 1'b0;
            REG_SEQX   <= REG_SEQX_NONE;
            REGA_ADDRX <= REGA_ADDRX_ARGA;
            REGB_ADDRX <= REGB_ADDRX_ARGB;
            ALU_OPX    <= '0;
            ALUA_SRCX  <= ALUA_SRCX_REG_A;
            ALUB_SRCX  <= ALUB_SRCX_REG_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            DONE    <= done_d;
            if (accept) begin
                ccl_q      <= (op != OPW'(OP_MOV));
                REG_SEQX   <= dec_seq;
                REGA_ADDRX <= dec_rega;
                REGB_ADDRX <= dec_regb;
                ALU_OPX    <= op;
                ALUA_SRCX  <= ALUA_SRCX_REG_A;
                ALUB_SRCX  <= dec_alub;
            end else if (release_ctl) begin
                ccl_q      <= 1'b0;
                REG_SEQX   <= REG_SEQX_NONE;
                REGA_ADDRX <= REGA_ADDRX_ARGA;
                REGB_ADDRX <= REGB_ADDRX_ARGB;
                ALU_OPX    <= '0;
                ALUA_SRCX  <= ALUA_SRCX_REG_A;
                ALUB_SRCX  <= ALUB_SRCX_REG_B;
            end
        end
    end

    assign ALU_STEP = step;
    assign STALL    = stall;
    assign CCL_LD   = ccl_q & step & final_step;

endmodule

// File: tb/tb_alu_group_sequencer.sv
// Randomized + directed bench for alu_group_sequencer against a per-transaction expectation model.
module tb_alu_group_sequencer;

    localparam logic [15:0] MASK = 16'h1000;
    localparam int          IDEF = 2;

    logic        CLK = 1'b0;
    logic        RESET, GROUP_VALID, DECODE, EXECUTE, COMMIT;
    logic [13:0] INSTRUCTION;
    logic [3:0]  REG_SEQX;
    logic [1:0]  REGA_ADDRX;
    logic [2:0]  REGB_ADDRX;
    logic [3:0]  ALU_OPX;
    logic        CCL_LD;
    logic [2:0]  ALUA_SRCX, ALUB_SRCX;
    logic        ALU_STEP, STALL, DONE;

    int total = 0;
    int bad   = 0;

    alu_group_sequencer #(.OPW(4), .ITERW(4), .MULTI_MASK(MASK), .ITER_DEF(IDEF)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .GROUP_VALID(GROUP_VALID),
        .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT),
        .REG_SEQX(REG_SEQX), .REGA_ADDRX(REGA_ADDRX), .REGB_ADDRX(REGB_ADDRX), .ALU_OPX(ALU_OPX),
        .CCL_LD(CCL_LD), .ALUA_SRCX(ALUA_SRCX), .ALUB_SRCX(ALUB_SRCX),
        .ALU_STEP(ALU_STEP), .STALL(STALL), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] seq;
        logic [1:0] rega;
        logic [2:0] regb;
        logic [3:0] op;
        logic [2:0] alua;
        logic [2:0] alub;
        bit         ccl;
        int         n;
    } exp_t;

    // Expected behaviour of one instruction, straight from the decode table
    function automatic exp_t model(input logic [13:0] ir);
        exp_t e;
        logic [3:0] op;
        logic [1:0] mode;
        int base;
        op   = ir[13:10];
        mode = ir[9:8];
        if (op == 4'h6 || op == 4'h7) base = 1;      // RDA_*
        else if (op == 4'h1)          base = 3;      // LDA_*
        else                          base = 5;      // UPA_*
        e.seq  = 4'(base + ((mode == 2'd0) ? 1 : 0));
        e.rega = (mode >= 2'd2) ? 2'd1 : 2'd0;
        e.regb = (mode == 2'd3) ? 3'd1 : 3'd0;
        e.alub = 3'(mode);
        e.alua = 3'd0;
        e.op   = op;
        e.ccl  = (op != 4'h1);
        if (!MASK[op])          e.n = 1;
        else if (mode == 2'd1)  e.n = (ir[3:0] == 0) ? 1 : int'(ir[3:0]);
        else                    e.n = IDEF;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [13:0] ir, input bit dflt);
        exp_t e;
        e = model(ir);
        if (dflt) begin
            e.seq = 4'd0; e.rega = 2'd0; e.regb = 3'd0; e.op = 4'd0; e.alua = 3'd0; e.alub = 3'd0;
        end
        chk({tag, ".seq"},  32'(REG_SEQX),   32'(e.seq));
        chk({tag, ".rega"}, 32'(REGA_ADDRX), 32'(e.rega));
        chk({tag, ".regb"}, 32'(REGB_ADDRX), 32'(e.regb));
        chk({tag, ".op"},   32'(ALU_OPX),    32'(e.op));
        chk({tag, ".alua"}, 32'(ALUA_SRCX),  32'(e.alua));
        chk({tag, ".alub"}, 32'(ALUB_SRCX),  32'(e.alub));
    endtask

    // One full DECODE/EXECUTE/COMMIT transaction; pre_armed means ir was latched by a chained COMMIT
    task automatic run_op(input string tag, input logic [13:0] ir, input bit pre_armed,
                          input bit chain, input logic [13:0] nxt, input bit poke);
        exp_t e;
        e = model(ir);
        if (!pre_armed) begin
            @(negedge CLK);
            INSTRUCTION = ir; DECODE = 1; GROUP_VALID = 1; EXECUTE = 0; COMMIT = 0;
            #1 chk({tag, ".idle_step"}, 32'(ALU_STEP), 0);
        end
        @(negedge CLK);
        DECODE = 0; GROUP_VALID = 0; COMMIT = 0; EXECUTE = 1;
        #1;
        chk({tag, ".done_in"}, 32'(DONE), 32'(pre_armed));
        chk_ctl({tag, ".armed"}, ir, 0);
        for (int k = 1; k <= e.n; k++) begin
            if (k > 1) begin
                @(negedge CLK);
                EXECUTE = 0;
                if (poke && k == 2) begin
                    DECODE = 1; GROUP_VALID = 1; INSTRUCTION = ir ^ 14'h3FFF;
                end else begin
                    DECODE = 0; GROUP_VALID = 0;
                end
                #1 chk_ctl({tag, ".iter"}, ir, 0);
            end
            chk({tag, ".step"},  32'(ALU_STEP), 1);
            chk({tag, ".stall"}, 32'(STALL),    32'(k < e.n));
            chk({tag, ".ccl"},   32'(CCL_LD),   32'(e.ccl && k == e.n));
        end
        @(negedge CLK);
        EXECUTE = 0; DECODE = 0; GROUP_VALID = 0;
        #1;
        chk({tag, ".wait_step"},  32'(ALU_STEP), 0);
        chk({tag, ".wait_stall"}, 32'(STALL),    0);
        chk({tag, ".wait_done"},  32'(DONE),     0);
        chk_ctl({tag, ".wait"}, ir, 0);
        COMMIT = 1;
        if (chain) begin
            DECODE = 1; GROUP_VALID = 1; INSTRUCTION = nxt;
        end else begin
            @(negedge CLK);
            COMMIT = 0;
            #1;
            chk({tag, ".done"}, 32'(DONE), 1);
            chk_ctl({tag, ".post"}, ir, 1);
            @(negedge CLK);
            #1 chk({tag, ".done_clr"}, 32'(DONE), 0);
        end
    endtask

    function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] mode, input logic [7:0] lo);
        return {op, mode, lo};
    endfunction

    initial begin
        logic [13:0] ir, nxt;
        bit pre, chain;

        RESET = 1; GROUP_VALID = 0; DECODE = 0; EXECUTE = 0; COMMIT = 0; INSTRUCTION = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk_ctl("reset", 14'd0, 1);
        chk("reset.step", 32'(ALU_STEP), 0);
        chk("reset.done", 32'(DONE), 0);
        RESET = 0;

        // Reset held two cycles while iterating
        @(negedge CLK);
        INSTRUCTION = mk(4'hC, 2'd1, 8'h05); DECODE = 1; GROUP_VALID = 1;
        @(negedge CLK);
        DECODE = 0; GROUP_VALID = 0; EXECUTE = 1;
        @(negedge CLK);
        EXECUTE = 0;
        #1 chk("rst_mid.in_iter", 32'(STALL), 1);
        RESET = 1;
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk_ctl("rst_mid", 14'd0, 1);
            chk("rst_mid.step",  32'(ALU_STEP), 0);
            chk("rst_mid.stall", 32'(STALL), 0);
            chk("rst_mid.done",  32'(DONE), 0);
        end
        RESET = 0; COMMIT = 1;
        @(negedge CLK);
        COMMIT = 0;
        #1 chk("rst_mid.commit_ignored", 32'(DONE), 0);
        EXECUTE = 1;
        #1 chk("rst_mid.idle_step", 32'(ALU_STEP), 0);
        EXECUTE = 0;

        // DECODE without GROUP_VALID is ignored
        @(negedge CLK);
        INSTRUCTION = mk(4'h2, 2'd0, 8'h00); DECODE = 1; GROUP_VALID = 0;
        @(negedge CLK);
        DECODE = 0; EXECUTE = 1;
        #1;
        chk_ctl("nogv", 14'd0, 1);
        chk("nogv.step", 32'(ALU_STEP), 0);
        EXECUTE = 0;

        run_op("add_rr",  mk(4'h2, 2'd0, 8'h00), 0, 0, 14'd0, 0);
        run_op("mov_u8",  mk(4'h1, 2'd2, 8'hA5), 0, 0, 14'd0, 0);
        run_op("multi5",  mk(4'hC, 2'd1, 8'h05), 0, 0, 14'd0, 0);
        run_op("multi0",  mk(4'hC, 2'd1, 8'h00), 0, 0, 14'd0, 0);
        run_op("multi_s8",mk(4'hC, 2'd3, 8'h7F), 0, 0, 14'd0, 0);
        run_op("poke",    mk(4'hC, 2'd1, 8'h03), 0, 0, 14'd0, 1);
        run_op("b2b_a",   mk(4'h2, 2'd0, 8'h00), 0, 1, mk(4'h6, 2'd1, 8'h09), 0);
        run_op("b2b_cmp", mk(4'h6, 2'd1, 8'h09), 1, 0, 14'd0, 0);

        pre = 0;
        ir  = 14'($urandom);
        for (int i = 0; i < 30; i++) begin
            chain = (i < 29) && ($urandom_range(0, 2) == 0);
            nxt   = 14'($urandom);
            run_op("rand", ir, pre, chain, nxt, 1'($urandom_range(0, 1)));
            pre = chain;
            ir  = chain ? nxt : 14'($urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
